// File: rtl/cpu_nios_cpu_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_nios_cpu_mul_pkg
// Purpose  : Shared definitions for the pipelined multiplier. Holds the
//            operation-mode encoding, the pipeline latency constant and
//            helpers that decode operand signedness from the mode.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_nios_cpu_mul_pkg;

  // Operation mode as presented on in_mode.
  typedef enum logic [1:0] {
    MUL    = 2'b00,  // low half of the product
    MULXSS = 2'b01,  // high half, A signed,   B signed
    MULXSU = 2'b10,  // high half, A signed,   B unsigned
    MULXUU = 2'b11   // high half, A unsigned, B unsigned
  } mul_mode_e;

  // Clock edges from the accepting edge to the result being visible,
  // counting the accepting edge itself.
  localparam int LATENCY = 3;

  // MUL only returns the low half, which is independent of signedness,
  // so it is treated as unsigned (no correction applied).
  function automatic logic a_is_signed(input mul_mode_e m);
    return (m == MULXSS) || (m == MULXSU);
  endfunction

  function automatic logic b_is_signed(input mul_mode_e m);
    return (m == MULXSS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_nios_cpu_mul_pp.sv
`default_nettype none
// ============================================================================
// Module   : cpu_nios_cpu_mul_pp
// Purpose  : Single registered unsigned multiplier of two half-width operands.
//            Written as a plain registered product so synthesis maps it onto a
//            dedicated multiplier block with its output register absorbed.
// Ports    : clk  - clock
//            i_en - load enable for the product register
//            i_a  - unsigned operand, HALF_W bits
//            i_b  - unsigned operand, HALF_W bits
//            o_p  - registered product, 2*HALF_W bits
// Revision : 1.0 - initial release
// ============================================================================
module cpu_nios_cpu_mul_pp #(
  parameter int HALF_W = 16
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic [HALF_W-1:0]     i_a,
  input  logic [HALF_W-1:0]     i_b,
  output logic [2*HALF_W-1:0]   o_p
);

  // Datapath register only; validity is tracked by the enclosing pipeline,
  // so no reset is needed here.
  logic [2*HALF_W-1:0] r_p;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_p <= {{HALF_W{1'b0}}, i_a} * {{HALF_W{1'b0}}, i_b};
    end
  end

  assign o_p = r_p;

endmodule
`default_nettype wire

// File: rtl/cpu_nios_cpu_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cpu_nios_cpu_mul_pipe
// Purpose  : Three-stage valid/ready multiplier supporting MUL (low half) and
//            MULXSS / MULXSU / MULXUU (high half) with a sideband tag.
//              S1: four half-width partial products, mode, tag, sign term
//              S2: full 2*DATA_W sum with two's-complement sign correction
//              S3: selected half and tag, presented on the output
// Ports    : clk, reset           - clock, synchronous active-high reset
//            in_valid/in_ready    - input handshake
//            in_src1/in_src2      - operands A and B (DATA_W)
//            in_mode              - mul_mode_e encoding
//            in_tag               - opaque tag returned with the result
//            flush                - drops every in-flight operation
//            out_valid/out_ready  - output handshake
//            out_result/out_tag   - result half and its tag (0 when idle)
// Revision : 1.0 - initial release
// ============================================================================
module cpu_nios_cpu_mul_pipe
  import cpu_nios_cpu_mul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PROD_W = 2 * DATA_W;

  // --------------------------------------------------------------------------
  // Stage control: a stage advances when it is empty or its successor
  // advances, so a full pipeline with out_ready=1 still takes a new input.
  // --------------------------------------------------------------------------
  logic r_s1_v, r_s2_v, r_s3_v;
  logic w_s1_adv, w_s2_adv, w_s3_adv;

  assign w_s3_adv = !r_s3_v || out_ready;
  assign w_s2_adv = !r_s2_v || w_s3_adv;
  assign w_s1_adv = !r_s1_v || w_s2_adv;
  assign in_ready = w_s1_adv;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_s3_v <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_v <= in_valid;
      if (w_s2_adv) r_s2_v <= r_s1_v;
      if (w_s3_adv) r_s3_v <= r_s2_v;
    end
  end

  // --------------------------------------------------------------------------
  // S1: partial products and sideband
  // --------------------------------------------------------------------------
  mul_mode_e             w_in_mode;
  logic [DATA_W-1:0]     w_corr;
  logic [DATA_W-1:0]     w_pp_ll, w_pp_lh, w_pp_hl, w_pp_hh;

  assign w_in_mode = mul_mode_e'(in_mode);

  // The operand sign bits are folded here into a single correction term:
  // (A<0 ? B : 0) + (B<0 ? A : 0), to be subtracted at weight 2^DATA_W.
  // Its carry out lands at 2^(2*DATA_W) and is irrelevant modulo the product.
  assign w_corr = ((a_is_signed(w_in_mode) && in_src1[DATA_W-1]) ? in_src2 : '0)
                + ((b_is_signed(w_in_mode) && in_src2[DATA_W-1]) ? in_src1 : '0);

  cpu_nios_cpu_mul_pp #(.HALF_W(HALF_W)) u_pp_ll (
    .clk  (clk),
    .i_en (w_s1_adv),
    .i_a  (in_src1[HALF_W-1:0]),
    .i_b  (in_src2[HALF_W-1:0]),
    .o_p  (w_pp_ll)
  );

  cpu_nios_cpu_mul_pp #(.HALF_W(HALF_W)) u_pp_lh (
    .clk  (clk),
    .i_en (w_s1_adv),
    .i_a  (in_src1[HALF_W-1:0]),
    .i_b  (in_src2[DATA_W-1:HALF_W]),
    .o_p  (w_pp_lh)
  );

  cpu_nios_cpu_mul_pp #(.HALF_W(HALF_W)) u_pp_hl (
    .clk  (clk),
    .i_en (w_s1_adv),
    .i_a  (in_src1[DATA_W-1:HALF_W]),
    .i_b  (in_src2[HALF_W-1:0]),
    .o_p  (w_pp_hl)
  );

  cpu_nios_cpu_mul_pp #(.HALF_W(HALF_W)) u_pp_hh (
    .clk  (clk),
    .i_en (w_s1_adv),
    .i_a  (in_src1[DATA_W-1:HALF_W]),
    .i_b  (in_src2[DATA_W-1:HALF_W]),
    .o_p  (w_pp_hh)
  );

  mul_mode_e          r_s1_mode;
  logic [TAG_W-1:0]   r_s1_tag;
  logic [DATA_W-1:0]  r_s1_corr;

  always_ff @(posedge clk) begin
    if (w_s1_adv) begin
      r_s1_mode <= w_in_mode;
      r_s1_tag  <= in_tag;
      r_s1_corr <= w_corr;
    end
  end

  // --------------------------------------------------------------------------
  // S2: sum of the partial products minus the sign correction
  // --------------------------------------------------------------------------
  logic [PROD_W-1:0]  w_sum;
  logic [PROD_W-1:0]  r_s2_prod;
  mul_mode_e          r_s2_mode;
  logic [TAG_W-1:0]   r_s2_tag;

  assign w_sum = {w_pp_hh, w_pp_ll}
               + {{HALF_W{1'b0}}, w_pp_lh, {HALF_W{1'b0}}}
               + {{HALF_W{1'b0}}, w_pp_hl, {HALF_W{1'b0}}}
               - {r_s1_corr, {DATA_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (w_s2_adv) begin
      r_s2_prod <= w_sum;
      r_s2_mode <= r_s1_mode;
      r_s2_tag  <= r_s1_tag;
    end
  end

  // --------------------------------------------------------------------------
  // S3: half selection and output register
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]  r_s3_res;
  logic [TAG_W-1:0]   r_s3_tag;

  always_ff @(posedge clk) begin
    if (w_s3_adv) begin
      r_s3_res <= (r_s2_mode == MUL) ? r_s2_prod[DATA_W-1:0]
                                     : r_s2_prod[PROD_W-1:DATA_W];
      r_s3_tag <= r_s2_tag;
    end
  end

  // Output registers are not reset; masking with the valid bit keeps the
  // visible result and tag at zero whenever nothing is being presented.
  assign out_valid  = r_s3_v;
  assign out_result = r_s3_v ? r_s3_res : '0;
  assign out_tag    = r_s3_v ? r_s3_tag : '0;

endmodule
`default_nettype wire

// File: tb/tb_cpu_nios_cpu_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_nios_cpu_mul_pipe
// Purpose  : Directed self-checking bench for cpu_nios_cpu_mul_pipe
//            (DATA_W=32, TAG_W=5): reset state, hand-computed vectors with
//            exact latency, streaming against a sign-extension model,
//            backpressure, flush and mid-stream reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_nios_cpu_mul_pipe;
  import cpu_nios_cpu_mul_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] q_res[$];
  logic [4:0]  q_tag[$];

  cpu_nios_cpu_mul_pipe #(.DATA_W(32), .TAG_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_mode    (in_mode),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: sign/zero-extend both operands to 64 bits and multiply.
  function automatic logic [31:0] ref_mul(input logic [1:0] m, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ax, bx, p;
    ax = (m == 2'b01 || m == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    bx = (m == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ax * bx;
    return (m == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    in_valid = 1'b1;
    in_mode  = m;
    in_src1  = a;
    in_src2  = b;
    in_tag   = t;
  endtask

  // Called at a negedge with out_valid=1: checks against the scoreboard head.
  task automatic pop_check(input string tag);
    logic [31:0] er;
    logic [4:0]  et;
    if (q_res.size() == 0) begin
      chk({tag, "_unexpected_out"}, out_valid, 1'b0);
    end else begin
      er = q_res.pop_front();
      et = q_tag.pop_front();
      chk({tag, "_result"}, out_result, er);
      chk({tag, "_tag"}, out_tag, et);
    end
  endtask

  // One operation through an empty pipeline with out_ready=1; the result must
  // be visible exactly after the third edge counting the accepting edge.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp);
    out_ready = 1'b1;
    drive(m, a, b, t);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_e1"}, out_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_valid_e2"}, out_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_valid_e3"}, out_valid, 1'b1);
    chk({tag, "_result"}, out_result, exp);
    chk({tag, "_tag"}, out_tag, t);
    @(negedge clk);
    chk({tag, "_valid_after"}, out_valid, 1'b0);
    chk({tag, "_result_idle"}, out_result, 32'h0);
    step();
  endtask

  // Offer three operations with out_ready=0 so they fill S1..S3.
  task automatic fill3(input string tag, input logic [4:0] base);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(2'(k), 32'h1000 + 32'(k), 32'h3, base + 5'(k));
      @(negedge clk);
      chk({tag, "_fill_in_ready"}, in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
  endtask

  // Count output-valid cycles over a window with out_ready=1.
  task automatic watch_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    out_ready = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
      step();
    end
    chk({tag, "_no_output"}, seen, 0);
  endtask

  logic [31:0] bp_a [5];
  logic [31:0] bp_b [5];
  logic [1:0]  bp_m [5];

  initial begin
    int idx;
    int n_out;
    logic [31:0] ra, rb;
    logic [1:0]  rm;

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_src1 = '0; in_src2 = '0; in_mode = '0; in_tag = '0;

    // ---------------- reset state ----------------
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_tag", out_tag, 5'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    step();

    // ---------------- directed vectors ----------------
    run_op("mulxss_neg1x2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1, 32'hFFFF_FFFF);
    run_op("mulxuu_ffx2",   2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 5'd2, 32'h0000_0001);
    run_op("mulxsu_min",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000);
    run_op("mul_low",       2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5'd4, 32'h242D_2080);
    run_op("mulxss_minsq",  2'b01, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000);
    run_op("mulxss_negpos", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5'd6, 32'hFFFF_FFFF);

    // ---------------- streaming ----------------
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom; rb = $urandom; rm = 2'($urandom_range(0, 3));
      drive(rm, ra, rb, 5'(i));
      @(negedge clk);
      chk("stream_in_ready", in_ready, 1'b1);
      if (out_valid) pop_check("stream");
      if (in_ready) begin
        q_res.push_back(ref_mul(rm, ra, rb));
        q_tag.push_back(5'(i));
      end
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) pop_check("stream_drain");
      step();
    end
    chk("stream_all_returned", q_res.size(), 0);

    // ---------------- backpressure ----------------
    for (int k = 0; k < 5; k++) begin
      bp_a[k] = 32'hF000_0001 + 32'(k * 7);
      bp_b[k] = 32'h0001_2345 * 32'(k + 1);
      bp_m[k] = 2'(k % 4);
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 5) drive(bp_m[idx], bp_a[idx], bp_b[idx], 5'(10 + idx));
      @(negedge clk);
      if (out_valid) begin
        chk("bp_hold_result", out_result, q_res[0]);
        chk("bp_hold_tag", out_tag, q_tag[0]);
      end
      if (in_valid && in_ready) begin
        q_res.push_back(ref_mul(bp_m[idx], bp_a[idx], bp_b[idx]));
        q_tag.push_back(5'(10 + idx));
        idx++;
      end
      step();
    end
    chk("bp_accepted", idx, 3);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_out_valid_held", out_valid, 1'b1);
    step();
    out_ready = 1'b1;
    n_out = 0;
    for (int c = 0; c < 30; c++) begin
      if (idx < 5) drive(bp_m[idx], bp_a[idx], bp_b[idx], 5'(10 + idx));
      else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        pop_check("bp_release");
        n_out++;
      end
      if (in_valid && in_ready) begin
        q_res.push_back(ref_mul(bp_m[idx], bp_a[idx], bp_b[idx]));
        q_tag.push_back(5'(10 + idx));
        idx++;
      end
      step();
      if (idx == 5 && q_res.size() == 0) break;
    end
    in_valid = 1'b0;
    chk("bp_out_count", n_out, 5);
    chk("bp_queue_empty", q_res.size(), 0);

    // ---------------- flush ----------------
    fill3("flush", 5'd20);
    drive(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd23);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_out_result", out_result, 32'h0);
    chk("flush_in_ready", in_ready, 1'b1);
    step();
    watch_quiet("flush", 6);
    // Flush with an empty pipeline and a live offer: the offer is dropped.
    drive(2'b00, 32'h7, 32'h9, 5'd24);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    watch_quiet("flush_empty", 5);
    run_op("after_flush", 2'b10, 32'hFFFF_FFF0, 32'h0000_0010, 5'd25, 32'hFFFF_FFFF);

    // ---------------- reset mid-stream ----------------
    fill3("rstmid", 5'd26);
    drive(2'b01, 32'h5, 32'h6, 5'd29);
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_out_valid", out_valid, 1'b0);
    chk("rstmid_out_result", out_result, 32'h0);
    chk("rstmid_out_tag", out_tag, 5'h0);
    chk("rstmid_in_ready", in_ready, 1'b1);
    step();
    watch_quiet("rstmid", 6);
    run_op("after_reset", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd30, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
